// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: pulls 64-bit instruction pairs from local store
// into a small FIFO and hands them to decode with a valid/ready handshake.
module instruction_fetch_stage #(
   parameter int LS_ADDR_WIDTH = 15,
   parameter int BUF_DEPTH     = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [0:LS_ADDR_WIDTH-1] imem_addr,
   input  logic                     imem_ack,
   input  logic [0:63]              imem_rdata,
   input  logic                     branch_taken,
   input  logic [0:LS_ADDR_WIDTH-1] branch_target,
   input  logic                     decode_ready,
   output logic                     pair_valid,
   output logic [0:31]              first_inst,
   output logic [0:31]              second_inst,
   output logic [0:LS_ADDR_WIDTH-1] pair_pc
);
   localparam int AW = LS_ADDR_WIDTH;
   localparam int PW = $clog2(BUF_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(BUF_DEPTH);
   localparam logic [0:31] EVEN_NOP = 32'h4020_0000;

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_DISCARD
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [0:AW-1] r_fetch_pc;
   logic          r_odd_start;
   logic          r_req;
   logic [0:AW-1] r_addr;
   logic [0:63]   r_data [BUF_DEPTH];
   logic [0:AW-1] r_pc   [BUF_DEPTH];
   logic          r_odd  [BUF_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;

   logic w_issue;
   logic w_push;
   logic w_pop;
   logic w_empty;
   logic w_unused_tgt;

   // Targets are word aligned, so the two lowest address bits carry nothing.
   assign w_unused_tgt = ^branch_target[AW-2:AW-1];

   assign w_empty = (r_count == '0);
   assign w_pop   = !w_empty && decode_ready && !branch_taken;

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_push      = 1'b0;
      unique case (r_state)
         S_FETCH: begin
            if (!branch_taken && (r_count < DEPTH_C)) begin
               w_issue     = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (branch_taken) begin
               w_state_nxt = imem_ack ? S_FETCH : S_DISCARD;
            end else if (imem_ack) begin
               w_push      = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         S_DISCARD: begin
            if (imem_ack) begin
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_fetch_pc  <= '0;
         r_odd_start <= 1'b0;
         r_req       <= 1'b0;
         r_addr      <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
      end else begin
         r_req <= w_issue;
         if (w_issue) begin
            r_addr <= {r_fetch_pc[0:AW-4], 3'b000};
         end
         if (branch_taken) begin
            r_fetch_pc  <= {branch_target[0:AW-4], 3'b000};
            r_odd_start <= branch_target[AW-3];
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
         end else begin
            if (w_push) begin
               r_fetch_pc  <= r_fetch_pc + AW'(8);
               r_odd_start <= 1'b0;
               r_wptr      <= r_wptr + 1'b1;
            end
            if (w_pop) begin
               r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
               r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
               r_count <= r_count - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset && w_push) begin
         r_data[r_wptr] <= imem_rdata;
         r_pc[r_wptr]   <= r_fetch_pc;
         r_odd[r_wptr]  <= r_odd_start;
      end
   end

   assign imem_req   = r_req;
   assign imem_addr  = r_addr;
   assign pair_valid = !w_empty;
   assign pair_pc    = w_empty ? '0 : r_pc[r_rptr];

   // A pair entered at its odd word replaces the skipped even slot with a NOP.
   assign first_inst = w_empty ? '0 :
                       (r_odd[r_rptr] ? EVEN_NOP : r_data[r_rptr][0:31]);
   assign second_inst = w_empty ? '0 : r_data[r_rptr][32:63];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios, a local-store
// responder, and a queue-based reference model checked every cycle.
module tb_instruction_fetch_stage;
   localparam int DEPTH = 4;
   localparam int LAT   = 2;

   logic        clock;
   logic        reset;
   logic        imem_req;
   logic [0:14] imem_addr;
   logic        imem_ack;
   logic [0:63] imem_rdata;
   logic        branch_taken;
   logic [0:14] branch_target;
   logic        decode_ready;
   logic        pair_valid;
   logic [0:31] first_inst;
   logic [0:31] second_inst;
   logic [0:14] pair_pc;

   instruction_fetch_stage #(
      .LS_ADDR_WIDTH(15),
      .BUF_DEPTH(DEPTH)
   ) dut (
      .clock(clock),
      .reset(reset),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .decode_ready(decode_ready),
      .pair_valid(pair_valid),
      .first_inst(first_inst),
      .second_inst(second_inst),
      .pair_pc(pair_pc)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   typedef struct {
      logic [14:0] pc;
      bit          odd;
   } ment_t;

   typedef struct {
      logic [14:0] pc;
      logic [31:0] f;
      logic [31:0] s;
   } pop_t;

   ment_t       mq[$];
   logic [14:0] m_pc;
   bit          m_odd;
   bit          m_out;
   bit          m_live;
   bit          m_req;
   logic [14:0] m_raddr;

   logic [14:0] reqs[$];
   pop_t        pops[$];
   int          pend;
   logic [14:0] pend_addr;

   function automatic logic [31:0] w(input logic [14:0] a);
      return 32'hC000_0000 | {17'd0, a};
   endfunction

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic logic [63:0] rq(input int i);
      if (i < reqs.size()) return 64'(reqs[i]);
      return '1;
   endfunction

   function automatic logic [63:0] pp(input int i, input int fld);
      if (i >= pops.size()) return '1;
      if (fld == 0) return 64'(pops[i].pc);
      if (fld == 1) return 64'(pops[i].f);
      return 64'(pops[i].s);
   endfunction

   task automatic model_step();
      int          cnt0;
      logic [14:0] t;
      m_req = 0;
      t = branch_target;
      if (!reset) begin
         mq.delete();
         m_pc   = '0;
         m_odd  = 0;
         m_out  = 0;
         m_live = 0;
      end else if (branch_taken) begin
         if (imem_ack) m_out = 0;
         m_live = 0;
         mq.delete();
         m_pc  = {t[14:3], 3'b000};
         m_odd = t[2];
      end else begin
         cnt0 = mq.size();
         if (mq.size() != 0 && decode_ready) void'(mq.pop_front());
         if (!m_out) begin
            if (cnt0 < DEPTH) begin
               m_req   = 1;
               m_raddr = m_pc;
               m_out   = 1;
               m_live  = 1;
            end
         end else if (imem_ack) begin
            if (m_live) begin
               mq.push_back('{m_pc, m_odd});
               m_pc  = 15'(m_pc + 15'd8);
               m_odd = 0;
            end
            m_out  = 0;
            m_live = 0;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clock);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         if (chk_en) begin
            chk("cyc_req", 64'(imem_req), 64'(m_req));
            if (m_req) chk("cyc_addr", 64'(imem_addr), 64'(m_raddr));
            chk("cyc_valid", 64'(pair_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
               chk("cyc_pc", 64'(pair_pc), 64'(mq[0].pc));
               chk("cyc_first", 64'(first_inst),
                   64'(mq[0].odd ? 32'h4020_0000 : w(mq[0].pc)));
               chk("cyc_second", 64'(second_inst),
                   64'(w(15'(mq[0].pc + 15'd4))));
            end
         end
      end
   end

   task automatic step();
      if (reset && pair_valid && decode_ready && !branch_taken)
         pops.push_back('{pair_pc, first_inst, second_inst});
      @(negedge clock);
      imem_ack = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = {w(pend_addr), w(15'(pend_addr + 15'd4))};
         end
      end
      if (reset && imem_req) begin
         reqs.push_back(imem_addr);
         pend_addr = imem_addr;
         pend      = LAT;
      end
   endtask

   task automatic do_reset();
      reset        = 1'b0;
      branch_taken = 1'b0;
      imem_ack     = 1'b0;
      pend         = 0;
      repeat (2) step();
      reqs.delete();
      pops.delete();
   endtask

   initial begin
      reset         = 1'b0;
      imem_ack      = 1'b0;
      imem_rdata    = '0;
      branch_taken  = 1'b0;
      branch_target = '0;
      decode_ready  = 1'b1;
      pend          = 0;

      do_reset();
      chk_en = 1;
      chk("rst_req", 64'(imem_req), 0);
      chk("rst_addr", 64'(imem_addr), 0);
      chk("rst_valid", 64'(pair_valid), 0);
      chk("rst_first", 64'(first_inst), 0);
      chk("rst_second", 64'(second_inst), 0);
      chk("rst_pc", 64'(pair_pc), 0);

      // Streaming fetch
      reset = 1'b1;
      repeat (20) step();
      chk("t1_req0", rq(0), 64'h0000);
      chk("t1_req1", rq(1), 64'h0008);
      chk("t1_req2", rq(2), 64'h0010);
      chk("t1_pop0_f", pp(0, 1), 64'hC000_0000);
      chk("t1_pop0_s", pp(0, 2), 64'hC000_0004);
      chk("t1_pop1_pc", pp(1, 0), 64'h0008);

      // Decode stalled: buffer fills, then drains in order
      decode_ready = 1'b0;
      do_reset();
      reset = 1'b1;
      repeat (30) step();
      chk("t2_req_cnt", 64'(reqs.size()), 4);
      chk("t2_hold_pc", 64'(pair_pc), 0);
      chk("t2_hold_f", 64'(first_inst), 64'hC000_0000);
      decode_ready = 1'b1;
      repeat (30) step();
      chk("t2_pop0", pp(0, 0), 64'h0000);
      chk("t2_pop1", pp(1, 0), 64'h0008);
      chk("t2_pop2", pp(2, 0), 64'h0010);
      chk("t2_pop3", pp(3, 0), 64'h0018);
      chk("t2_resume", 64'(reqs.size() > 4), 1);

      // Redirect while a request is outstanding
      do_reset();
      reset = 1'b1;
      for (int i = 0; i < 10 && !imem_req; i++) step();
      chk("t3_req_seen", 64'(imem_req), 1);
      step();
      branch_taken  = 1'b1;
      branch_target = 15'h0104;
      reqs.delete();
      pops.delete();
      step();
      branch_taken = 1'b0;
      repeat (20) step();
      chk("t3_req0", rq(0), 64'h0100);
      chk("t3_pop_pc", pp(0, 0), 64'h0100);
      chk("t3_pop_f", pp(0, 1), 64'h4020_0000);
      chk("t3_pop_s", pp(0, 2), 64'hC000_0104);

      // Redirect coinciding with the ack
      do_reset();
      reset = 1'b1;
      for (int i = 0; i < 20 && !imem_ack; i++) step();
      chk("t4_ack_seen", 64'(imem_ack), 1);
      branch_taken  = 1'b1;
      branch_target = 15'h0200;
      reqs.delete();
      pops.delete();
      step();
      branch_taken = 1'b0;
      repeat (15) step();
      chk("t4_req0", rq(0), 64'h0200);
      chk("t4_pop_pc", pp(0, 0), 64'h0200);
      chk("t4_pop_f", pp(0, 1), 64'hC000_0200);

      // Back-to-back branches, then address wrap
      do_reset();
      reset         = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 15'h0404;
      step();
      branch_target = 15'h7FF8;
      step();
      branch_taken = 1'b0;
      repeat (20) step();
      chk("t5_req0", rq(0), 64'h7FF8);
      chk("t5_req1", rq(1), 64'h0000);
      chk("t5_pop0_pc", pp(0, 0), 64'h7FF8);
      chk("t5_pop0_f", pp(0, 1), 64'hC000_7FF8);
      chk("t5_pop1_pc", pp(1, 0), 64'h0000);

      // Reset during WAIT, stale ack right after release
      do_reset();
      reset = 1'b1;
      repeat (10) step();
      for (int i = 0; i < 10 && !imem_req; i++) step();
      chk("t6_req_seen", 64'(imem_req), 1);
      reset = 1'b0;
      pend  = 0;
      step();
      chk("t6_rst_req", 64'(imem_req), 0);
      chk("t6_rst_valid", 64'(pair_valid), 0);
      chk("t6_rst_addr", 64'(imem_addr), 0);
      chk("t6_rst_first", 64'(first_inst), 0);
      chk("t6_rst_pc", 64'(pair_pc), 0);
      reset      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      reqs.delete();
      pops.delete();
      repeat (20) step();
      chk("t6_req0", rq(0), 64'h0000);
      chk("t6_pop_f", pp(0, 1), 64'hC000_0000);
      chk("t6_pop_s", pp(0, 2), 64'hC000_0004);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
